// File: rtl/ymz_rom_arbiter_pkg.sv
// Shared types and constants for the YMZ280B sample-ROM arbiter.
// Bank decoding helpers live here so the top stays free of bank muxing detail.
package ymz_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]  BANK_PCM     = 2'b00;
    localparam logic [1:0]  BANK_PCM1    = 2'b01;
    localparam logic [1:0]  BANK_PCM2    = 2'b10;
    localparam logic [1:0]  BANK_OOR     = 2'b11;
    localparam logic [7:0]  DEFAULT_BYTE = 8'h00;
    localparam logic [21:0] BANK_SIZE    = 22'h3FFFFF;

    // Out-of-range bank maps to no chip select at all.
    function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
        logic [2:0] sel;
        sel = 3'b000;
        case (bank)
            BANK_PCM:  sel = 3'b001;
            BANK_PCM1: sel = 3'b010;
            BANK_PCM2: sel = 3'b100;
            default:   sel = 3'b000;
        endcase
        return sel;
    endfunction

    function automatic logic [7:0] bank_byte(input logic [23:0] dout, input logic [1:0] bank);
        logic [7:0] b;
        b = DEFAULT_BYTE;
        case (bank)
            BANK_PCM:  b = dout[7:0];
            BANK_PCM1: b = dout[15:8];
            BANK_PCM2: b = dout[23:16];
            default:   b = DEFAULT_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ymz_rom_arbiter.sv
// Serialises YMZ280B byte reads onto three PCM SDRAM banks, with a one-entry
// last-address cache, an out-of-range responder, a stall watchdog and abort.
module ymz_rom_arbiter
    import ymz_rom_pkg::*;
#(
    parameter int AW      = 24,
    parameter int BANK_AW = 22,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               YMZ_RD,
    input  logic [AW-1:0]      YMZ_ADDR,
    output logic [7:0]         YMZ_DOUT,
    output logic               YMZ_VALID,
    input  logic               HIT_EN,
    output logic [2:0]         PCM_CS,
    output logic [BANK_AW-1:0] PCM_ADDR,
    input  logic [2:0]         PCM_OK,
    input  logic [23:0]        PCM_DOUT,
    output logic               TIMEOUT_ERR,
    input  logic               ERR_CLR
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [1:0]         bank_q, bank_d;
    logic [2:0]         cs_q, cs_d;
    logic [BANK_AW-1:0] pcm_addr_q, pcm_addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               valid_q, valid_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               cache_vld_q, cache_vld_d;
    logic [AW-1:0]      cache_addr_q, cache_addr_d;
    logic [7:0]         cache_data_q, cache_data_d;

    logic [1:0]         req_bank;
    logic               ok_sel;
    logic               cache_hit;
    logic               timeout_set;

    assign req_bank  = YMZ_ADDR[AW-1 -: 2];
    assign ok_sel    = |(PCM_OK & bank_onehot(bank_q));
    assign cache_hit = HIT_EN && cache_vld_q && (YMZ_ADDR == cache_addr_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        bank_d       = bank_q;
        cs_d         = cs_q;
        pcm_addr_d   = pcm_addr_q;
        dout_d       = dout_q;
        valid_d      = 1'b0;
        cnt_d        = cnt_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
        timeout_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (YMZ_RD) begin
                    addr_d = YMZ_ADDR;
                    bank_d = req_bank;
                    if (req_bank == BANK_OOR) begin
                        dout_d  = DEFAULT_BYTE;
                        valid_d = 1'b1;
                        state_d = RESP;
                    end else if (cache_hit) begin
                        dout_d  = cache_data_q;
                        valid_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        cs_d       = bank_onehot(req_bank);
                        pcm_addr_d = YMZ_ADDR[BANK_AW-1:0];
                        cnt_d      = 8'd0;
                        state_d    = WAIT;
                    end
                end
            end
            // Data return beats abort, abort beats the watchdog.
            WAIT: begin
                if (ok_sel) begin
                    dout_d       = bank_byte(PCM_DOUT, bank_q);
                    cache_vld_d  = 1'b1;
                    cache_addr_d = addr_q;
                    cache_data_d = bank_byte(PCM_DOUT, bank_q);
                    cs_d         = 3'b000;
                    valid_d      = 1'b1;
                    state_d      = RESP;
                end else if (!YMZ_RD) begin
                    cs_d    = 3'b000;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    dout_d      = DEFAULT_BYTE;
                    timeout_set = 1'b1;
                    cs_d        = 3'b000;
                    valid_d     = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                cs_d    = 3'b000;
                state_d = IDLE;
            end
            default: begin
                cs_d    = 3'b000;
                state_d = IDLE;
            end
        endcase
    end

    // A clear request loses to a watchdog expiry in the same cycle.
    always_comb begin
        err_d = err_q;
        if (ERR_CLR) begin
            err_d = 1'b0;
        end
        if (timeout_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            bank_q       <= BANK_PCM;
            cs_q         <= 3'b000;
            pcm_addr_q   <= '0;
            dout_q       <= DEFAULT_BYTE;
            valid_q      <= 1'b0;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= DEFAULT_BYTE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bank_q       <= bank_d;
            cs_q         <= cs_d;
            pcm_addr_q   <= pcm_addr_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
        end
    end

    assign YMZ_DOUT    = dout_q;
    assign YMZ_VALID   = valid_q;
    assign PCM_CS      = cs_q;
    assign PCM_ADDR    = pcm_addr_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_ymz_rom_arbiter.sv
// Directed bench for ymz_rom_arbiter: expected responses are queued when a
// request is issued and matched (data and cycle) whenever YMZ_VALID appears.
module tb_ymz_rom_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        YMZ_RD;
    logic [23:0] YMZ_ADDR;
    logic [7:0]  YMZ_DOUT;
    logic        YMZ_VALID;
    logic        HIT_EN;
    logic [2:0]  PCM_CS;
    logic [21:0] PCM_ADDR;
    logic [2:0]  PCM_OK;
    logic [23:0] PCM_DOUT;
    logic        TIMEOUT_ERR;
    logic        ERR_CLR;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic got_valid = 1'b0;

    ymz_rom_arbiter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .YMZ_RD      (YMZ_RD),
        .YMZ_ADDR    (YMZ_ADDR),
        .YMZ_DOUT    (YMZ_DOUT),
        .YMZ_VALID   (YMZ_VALID),
        .HIT_EN      (HIT_EN),
        .PCM_CS      (PCM_CS),
        .PCM_ADDR    (PCM_ADDR),
        .PCM_OK      (PCM_OK),
        .PCM_DOUT    (PCM_DOUT),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_CLR     (ERR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and any response is scored.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (YMZ_VALID) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("resp_data", 32'(YMZ_DOUT), 32'(e.data));
                checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
            YMZ_RD    = 1'b0;
            got_valid = 1'b1;
        end
    endtask

    task automatic pushExp(input logic [7:0] data, input int offset);
        exp_t e;
        e.data = data;
        e.cyc  = cyc + 1 + offset;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [23:0] addr, input logic hit);
        YMZ_ADDR  = addr;
        HIT_EN    = hit;
        YMZ_RD    = 1'b1;
        got_valid = 1'b0;
        tick();
    endtask

    task automatic waitValid(input int limit);
        for (int i = 0; i < limit && !got_valid; i++) tick();
        checkOutput("valid_in_budget", 32'(got_valid), 32'd1);
    endtask

    // Miss with OK raised d cycles after CS rises; optional stray OK and address wobble.
    task automatic doMiss(input logic [23:0] addr, input logic hit, input int d,
                          input logic [2:0] exp_cs, input logic [7:0] exp_byte, input logic stray);
        pushExp(exp_byte, d + 1);
        applyStimulus(addr, hit);
        checkOutput("cs_rise", 32'(PCM_CS), 32'(exp_cs));
        checkOutput("pcm_addr", 32'(PCM_ADDR), 32'(addr[21:0]));
        if (stray) begin
            YMZ_ADDR = 24'hABCDEF;
            PCM_OK   = ~exp_cs;
        end
        repeat (d) tick();
        checkOutput("cs_hold", 32'(PCM_CS), 32'(exp_cs));
        checkOutput("addr_hold", 32'(PCM_ADDR), 32'(addr[21:0]));
        PCM_OK = exp_cs;
        tick();
        PCM_OK = 3'b000;
        checkOutput("miss_valid", 32'(got_valid), 32'd1);
        checkOutput("cs_drop", 32'(PCM_CS), 32'd0);
        tick();
        checkOutput("valid_pulse", 32'(YMZ_VALID), 32'd0);
    endtask

    // Hit or out-of-range: response one cycle after the request, no chip select.
    task automatic doQuick(input logic [23:0] addr, input logic hit, input logic [7:0] exp_byte,
                           input logic [21:0] hold_addr);
        pushExp(exp_byte, 0);
        applyStimulus(addr, hit);
        checkOutput("quick_valid", 32'(got_valid), 32'd1);
        checkOutput("quick_no_cs", 32'(PCM_CS), 32'd0);
        checkOutput("quick_addr_hold", 32'(PCM_ADDR), 32'(hold_addr));
        tick();
        checkOutput("valid_pulse", 32'(YMZ_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        RESET_N  = 1'b0;
        YMZ_RD   = 1'b0;
        YMZ_ADDR = 24'h0;
        HIT_EN   = 1'b0;
        PCM_OK   = 3'b000;
        PCM_DOUT = 24'hC35A3C;
        ERR_CLR  = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_dout", 32'(YMZ_DOUT), 32'd0);
        checkOutput("rst_valid", 32'(YMZ_VALID), 32'd0);
        checkOutput("rst_cs", 32'(PCM_CS), 32'd0);
        checkOutput("rst_addr", 32'(PCM_ADDR), 32'd0);
        checkOutput("rst_err", 32'(TIMEOUT_ERR), 32'd0);
        RESET_N = 1'b1;
        tick();

        $display("[TB] bank decode");
        doMiss(24'h000010, 1'b0, 3, 3'b001, 8'h3C, 1'b1);
        doMiss(24'h800010, 1'b0, 3, 3'b100, 8'hC3, 1'b0);
        doMiss(24'h400010, 1'b0, 3, 3'b010, 8'h5A, 1'b0);

        $display("[TB] out-of-range and hit");
        doQuick(24'hC00000, 1'b0, 8'h00, 22'h000010);
        doQuick(24'h400010, 1'b1, 8'h5A, 22'h000010);
        PCM_DOUT = 24'hC3773C;
        doMiss(24'h400010, 1'b0, 0, 3'b010, 8'h77, 1'b0);

        $display("[TB] watchdog");
        pushExp(8'h00, 256);
        applyStimulus(24'h000020, 1'b0);
        checkOutput("to_cs", 32'(PCM_CS), 32'd1);
        checkOutput("to_err_before", 32'(TIMEOUT_ERR), 32'd0);
        waitValid(300);
        checkOutput("to_err_set", 32'(TIMEOUT_ERR), 32'd1);
        checkOutput("to_cs_drop", 32'(PCM_CS), 32'd0);
        repeat (3) tick();
        checkOutput("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        checkOutput("to_err_clr", 32'(TIMEOUT_ERR), 32'd0);
        doMiss(24'h000020, 1'b1, 1, 3'b001, 8'h3C, 1'b0);

        $display("[TB] watchdog with clear held");
        pushExp(8'h00, 256);
        applyStimulus(24'h800020, 1'b0);
        ERR_CLR = 1'b1;
        waitValid(300);
        checkOutput("set_wins", 32'(TIMEOUT_ERR), 32'd1);
        ERR_CLR = 1'b0;
        tick();
        checkOutput("set_wins_hold", 32'(TIMEOUT_ERR), 32'd1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        checkOutput("set_wins_clr", 32'(TIMEOUT_ERR), 32'd0);

        $display("[TB] abort");
        applyStimulus(24'h800040, 1'b0);
        checkOutput("abort_cs", 32'(PCM_CS), 32'd4);
        tick();
        YMZ_RD = 1'b0;
        tick();
        checkOutput("abort_cs_drop", 32'(PCM_CS), 32'd0);
        checkOutput("abort_no_valid", 32'(YMZ_VALID), 32'd0);
        PCM_OK = 3'b100;
        repeat (3) tick();
        PCM_OK = 3'b000;
        checkOutput("abort_late_ok", 32'(PCM_CS), 32'd0);
        doQuick(24'h000020, 1'b1, 8'h3C, 22'h000040);

        $display("[TB] reset during wait");
        applyStimulus(24'h400080, 1'b0);
        checkOutput("rw_cs", 32'(PCM_CS), 32'd2);
        #2;
        RESET_N = 1'b0;
        YMZ_RD  = 1'b0;
        #1;
        checkOutput("rw_cs_drop", 32'(PCM_CS), 32'd0);
        checkOutput("rw_valid", 32'(YMZ_VALID), 32'd0);
        checkOutput("rw_dout", 32'(YMZ_DOUT), 32'd0);
        checkOutput("rw_addr", 32'(PCM_ADDR), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        doMiss(24'h000020, 1'b1, 1, 3'b001, 8'h3C, 1'b0);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ymz_rom_arbiter.md
# ymz_rom_arbiter

Sequences YMZ280B sample-ROM reads onto the three PCM SDRAM ports (PCM, PCM1, PCM2) used by the bakraid sound board.
- Latches one byte request from the YMZ280B ROM interface and decodes it to a bank by address range.
- Holds chip-select and address stable until the SDRAM OK returns, then hands back one data byte with a single-cycle valid pulse.
- Adds a last-address reuse path, an out-of-range responder, a stall watchdog and a requester-abort path, so the sound top level needs no combinational bank muxing.

## Interface
Parameters:
- AW, 24: YMZ280B ROM address width
- BANK_AW, 22: per-bank SDRAM address width (4 MB banks)
- TIMEOUT, 255: cycles in WAIT without OK before a forced response (8-bit counter)

Ports:
- CLK  in  1  system clock, SDRAM-aligned
- RESET_N  in  1  asynchronous, active-low reset
- YMZ_RD  in  1  read request level; held high by YMZ280B until YMZ_VALID
- YMZ_ADDR  in  24  byte address
- YMZ_DOUT  out  8  returned byte, valid with YMZ_VALID, held afterwards
- YMZ_VALID  out  1  one-cycle response pulse
- HIT_EN  in  1  enables last-address reuse
- PCM_CS  out  3  one-hot bank select: bit0 = PCM, bit1 = PCM1, bit2 = PCM2
- PCM_ADDR  out  22  shared bank address, stable while any PCM_CS bit is high
- PCM_OK  in  3  per-bank data-ready
- PCM_DOUT  in  24  per-bank data: [7:0] bank0, [15:8] bank1, [23:16] bank2
- TIMEOUT_ERR  out  1  sticky watchdog flag
- ERR_CLR  in  1  clears TIMEOUT_ERR

## Operation
- States: IDLE, WAIT, RESP.
- Reset: all outputs 0, state IDLE, cache invalid, watchdog counter 0.
- IDLE with YMZ_RD=1:
  - Latch the address.
  - Bank = addr[23:22].
  - Bank 3 (address ≥ 0xC00000): YMZ_DOUT=0x00, go to RESP. No PCM_CS.
  - HIT_EN=1, cache valid and addr == cached addr: YMZ_DOUT = cached byte, go to RESP. No PCM_CS.
  - Otherwise: PCM_CS[bank]=1, PCM_ADDR=addr[21:0], counter cleared, go to WAIT.
- WAIT:
  - PCM_OK[bank]=1: capture the matching PCM_DOUT slice into YMZ_DOUT and the cache; mark cache valid; go to RESP.
  - OK bits of non-selected banks are ignored.
  - YMZ_ADDR changes during WAIT are ignored; the latched address is used.
  - YMZ_RD=0 (abort): drop PCM_CS, go to IDLE, no YMZ_VALID, cache unchanged.
  - Counter reaches TIMEOUT: YMZ_DOUT=0x00, TIMEOUT_ERR=1, cache unchanged, go to RESP.
- RESP:
  - YMZ_VALID=1 for exactly this one cycle; PCM_CS=0.
  - YMZ_RD is ignored in this state.
  - Next state is IDLE.
- TIMEOUT_ERR:
  - ERR_CLR=1 clears it.
  - If ERR_CLR and a new timeout occur in the same cycle, the set wins.
- Cache: one entry (24-bit address + 8-bit data). It is invalidated only by reset.

## Timing
- All outputs are registered.
- Cycle 0: YMZ_RD sampled high in IDLE.
- Hit or out-of-range: YMZ_VALID at cycle 1.
- Miss: PCM_CS and PCM_ADDR valid from cycle 1. OK sampled at cycle n ≥ 1 → YMZ_VALID, YMZ_DOUT and PCM_CS=0 at cycle n+1. Minimum miss latency is 2 cycles.
- Back-to-back requests: the next request is sampled no earlier than the cycle after YMZ_VALID. Peak rate is one response per 2 cycles on a hit, one per 3 on a miss.
- Timeout: the response occurs TIMEOUT+1 cycles after CS rises.
- PCM_ADDR keeps its last value when PCM_CS=0.
- RESET_N low at any point forces IDLE within the same cycle (asynchronous) and drops PCM_CS and YMZ_VALID.

## Structure
- Package ymz_rom_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - bank index constants, including BANK_OOR = 2'b11
  - DEFAULT_BYTE = 8'h00
  - bank size constant 22'h3FFFFF
- Single module with no sub-module; the watchdog counter is inline.

## Test plan
- Bank decode: read 0x000010, then 0x400010, then 0x800010, with OK after 3 cycles → PCM_CS = 001 / 010 / 100, PCM_ADDR = 0x000010, YMZ_DOUT equals the driven slice, YMZ_VALID one cycle at CS-rise+4.
- Out-of-range and hit: read 0xC00000 → YMZ_VALID at cycle 1, data 0x00, no CS. With HIT_EN=1, reread 0x400010 → data 0x5A returned at cycle 1 with no CS. With HIT_EN=0, the same read goes to SDRAM.
- Timeout: OK never asserted → YMZ_VALID 256 cycles after CS rise, data 0x00, TIMEOUT_ERR=1 until ERR_CLR pulses. The cache is not updated, so the same address misses next time.
- Abort: YMZ_RD dropped 2 cycles into WAIT → PCM_CS low next cycle, no YMZ_VALID, state IDLE. An OK arriving afterwards is ignored.
- Reset mid-WAIT: RESET_N low while CS is high → all outputs 0 immediately; after release the first read of the previous address is a miss.
- Stray OK: PCM_OK=3'b110 while bank0 is selected → no response until PCM_OK[0].
